// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single RAM port between the instruction-fetch requester and the
// load/store requester. Picks a winner in IDLE, registers its address and
// controls onto the mem_* bus, runs the MOV/MOC four-phase handshake and
// returns read data with a one-cycle acknowledge to the winner. If MOC does
// not arrive within TMO cycles the access is abandoned and the ack is
// accompanied by err.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> on contention, the requester that did not
//                                    win last time is granted.
//                       undefined -> fixed priority, data over fetch.
//
// Parameters:
//   TMO        cycles to wait for mem_moc before aborting (0 = never), 0..255
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   req_f      fetch request (always a word read)
//   addr_f     fetch address
//   ack_f      one-cycle fetch completion pulse
//   req_d      data request
//   rw_d       1 = read, 0 = write
//   addr_d     data address
//   wdata_d    store data
//   type_d     data type code (byte/half/word/dword)
//   sign_d     sign-extend loads
//   ack_d      one-cycle data completion pulse
//   err        pulses with the ack when the access timed out
//   rdata      read data, valid in the ack cycle, held until next completion
//   mem_mov    memory operation valid
//   mem_rw     registered R/W to the RAM
//   mem_addr   registered address to the RAM
//   mem_wdata  registered write data to the RAM
//   mem_type   registered data type to the RAM
//   mem_sign   registered sign control to the RAM
//   mem_moc    memory operation complete from the RAM
//   mem_rdata  RAM read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TMO = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_f,
    input  logic [31:0] addr_f,
    output logic        ack_f,
    input  logic        req_d,
    input  logic        rw_d,
    input  logic [31:0] addr_d,
    input  logic [31:0] wdata_d,
    input  logic [1:0]  type_d,
    input  logic        sign_d,
    output logic        ack_d,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_type,
    output logic        mem_sign,
    input  logic        mem_moc,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] TYPE_WORD = 2'b10;
    localparam logic       TMO_EN    = (TMO != 0);
    localparam logic [7:0] TMO_LAST  = (TMO == 0) ? 8'd0 : 8'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    // Owner of the access in flight (1 = data). Ack routing needs it in both
    // builds; with round-robin it also serves as the last-grant record.
    logic        owner_d_q;

    logic        pick_d;     // data wins the current arbitration
    logic        start;      // IDLE -> ACCESS this cycle
    logic        done;       // MOC seen in ACCESS
    logic        tmo_hit;    // MOC never came; abandon the access

    // Winner selection, only meaningful in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
    // On contention, grant whoever did not win last time (reset: fetch won).
    assign pick_d = req_d && (!req_f || !owner_d_q);
`else
    assign pick_d = req_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_f || req_d) begin
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_moc) begin
                    done    = 1'b1;
                    state_d = RELEASE;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    tmo_hit = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Four-phase completion: MOC must fall before the next MOV.
                if (!mem_moc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, handshake and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            owner_d_q <= 1'b0;
            ack_f     <= 1'b0;
            ack_d     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            mem_mov   <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_type  <= 2'b00;
            mem_sign  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_f   <= 1'b0;
            ack_d   <= 1'b0;
            err     <= 1'b0;

            if (start) begin
                owner_d_q <= pick_d;
                mem_mov   <= 1'b1;
                cnt_q     <= 8'd0;
                if (pick_d) begin
                    mem_rw    <= rw_d;
                    mem_addr  <= addr_d;
                    mem_wdata <= wdata_d;
                    mem_type  <= type_d;
                    mem_sign  <= sign_d;
                end else begin
                    // Fetch is a word read; write data is left as it was.
                    mem_rw   <= 1'b1;
                    mem_addr <= addr_f;
                    mem_type <= TYPE_WORD;
                    mem_sign <= 1'b0;
                end
            end

            if ((state_q == ACCESS) && !done && !tmo_hit) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (done || tmo_hit) begin
                mem_mov <= 1'b0;
                ack_f   <= !owner_d_q;
                ack_d   <= owner_d_q;
                err     <= tmo_hit;
                if (done && mem_rw) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter: directed scenarios, one task each.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_f;
    logic [31:0] addr_f;
    logic        ack_f;
    logic        req_d;
    logic        rw_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [1:0]  type_d;
    logic        sign_d;
    logic        ack_d;
    logic        err;
    logic [31:0] rdata;
    logic        mem_mov;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic        mem_sign;
    logic        mem_moc;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TMO(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_f     (req_f),
        .addr_f    (addr_f),
        .ack_f     (ack_f),
        .req_d     (req_d),
        .rw_d      (rw_d),
        .addr_d    (addr_d),
        .wdata_d   (wdata_d),
        .type_d    (type_d),
        .sign_d    (sign_d),
        .ack_d     (ack_d),
        .err       (err),
        .rdata     (rdata),
        .mem_mov   (mem_mov),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_type  (mem_type),
        .mem_sign  (mem_sign),
        .mem_moc   (mem_moc),
        .mem_rdata (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic saw_ack;
        clr = 1'b0; req_f = 0; req_d = 0; addr_f = 0; addr_d = 0; rw_d = 1;
        wdata_d = 0; type_d = 0; sign_d = 0; mem_moc = 0; mem_rdata = 0;
        step(); step();
        n_cmp++;
        if (mem_mov !== 1'b0 || mem_rw !== 1'b1 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
            mem_type !== 2'b00 || mem_sign !== 1'b0 || ack_f !== 1'b0 || ack_d !== 1'b0 ||
            err !== 1'b0 || rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: mov=%b rw=%b addr=%h wd=%h type=%b sign=%b ackf=%b ackd=%b err=%b rdata=%h",
                     mem_mov, mem_rw, mem_addr, mem_wdata, mem_type, mem_sign, ack_f, ack_d, err, rdata);
        end
        clr = 1'b1;
        // Start an access, then yank reset while it is in flight.
        req_f = 1'b1; addr_f = 32'h44;
        step();
        n_cmp++;
        if (mem_mov !== 1'b1 || mem_addr !== 32'h44) begin
            n_bad++;
            $display("FAIL reset_pre_access: mov=%b addr=%h, need mov=1 addr=00000044", mem_mov, mem_addr);
        end
        req_f = 1'b0;
        #2 clr = 1'b0;
        #1;
        n_cmp++;
        if (mem_mov !== 1'b0 || mem_rw !== 1'b1 || mem_addr !== 32'd0 || mem_type !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_async: mov=%b rw=%b addr=%h type=%b, need 0 1 0 0",
                     mem_mov, mem_rw, mem_addr, mem_type);
        end
        #1 clr = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_f || ack_d || err || mem_mov) saw_ack = 1'b1;
        end
        n_cmp++;
        if (saw_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_ack: activity seen after reset=%b, need 0", saw_ack);
        end
    endtask

    task automatic test_fetch();
        req_f = 1'b1; addr_f = 32'h40; mem_rdata = 32'h8A00_0001;
        step();
        n_cmp++;
        if (mem_mov !== 1'b1 || mem_addr !== 32'h40 || mem_rw !== 1'b1 ||
            mem_type !== 2'b10 || mem_sign !== 1'b0 || ack_f !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_issue: mov=%b addr=%h rw=%b type=%b sign=%b ack=%b, need 1 40 1 10 0 0",
                     mem_mov, mem_addr, mem_rw, mem_type, mem_sign, ack_f);
        end
        step();
        n_cmp++;
        if (ack_f !== 1'b0 || mem_mov !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_wait: ack_f=%b mov=%b, need 0 1", ack_f, mem_mov);
        end
        mem_moc = 1'b1;
        step();
        n_cmp++;
        if (ack_f !== 1'b1 || ack_d !== 1'b0 || err !== 1'b0 || rdata !== 32'h8A00_0001 || mem_mov !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_ack: ack_f=%b ack_d=%b err=%b rdata=%h mov=%b, need 1 0 0 8a000001 0",
                     ack_f, ack_d, err, rdata, mem_mov);
        end
        req_f = 1'b0; mem_moc = 1'b0;
        step();
        n_cmp++;
        if (ack_f !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_ack_width: ack_f=%b one cycle later, need 0", ack_f);
        end
        step();
    endtask

    task automatic test_store();
        req_d = 1'b1; rw_d = 1'b0; addr_d = 32'h100; wdata_d = 32'hDEAD_BEEF;
        type_d = 2'b00; sign_d = 1'b0; mem_rdata = 32'h1234_5678;
        step();
        n_cmp++;
        if (mem_mov !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 32'h100 ||
            mem_wdata !== 32'hDEAD_BEEF || mem_type !== 2'b00 || mem_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL store_issue: mov=%b rw=%b addr=%h wd=%h type=%b sign=%b, need 1 0 100 deadbeef 00 0",
                     mem_mov, mem_rw, mem_addr, mem_wdata, mem_type, mem_sign);
        end
        step();
        mem_moc = 1'b1;
        step();
        n_cmp++;
        if (ack_d !== 1'b1 || ack_f !== 1'b0 || err !== 1'b0 || rdata !== 32'h8A00_0001) begin
            n_bad++;
            $display("FAIL store_ack: ack_d=%b ack_f=%b err=%b rdata=%h, need 1 0 0 8a000001",
                     ack_d, ack_f, err, rdata);
        end
        req_d = 1'b0; mem_moc = 1'b0;
        step(); step();
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr [4];
        logic        got_mov;
`ifdef ARB_ROUND_ROBIN_EN
        exp_addr = '{32'h300, 32'h200, 32'h300, 32'h200};
`else
        exp_addr = '{32'h300, 32'h300, 32'h300, 32'h300};
`endif
        clr = 1'b0;
        step();
        clr = 1'b1;
        req_f = 1'b1; addr_f = 32'h200;
        req_d = 1'b1; rw_d = 1'b1; addr_d = 32'h300; type_d = 2'b10; sign_d = 1'b0;
        mem_rdata = 32'h0000_0C0C;
        for (int a = 0; a < 4; a++) begin
            got_mov = 1'b0;
            for (int w = 0; w < 8 && !got_mov; w++) begin
                step();
                if (mem_mov) got_mov = 1'b1;
            end
            n_cmp++;
            if (got_mov !== 1'b1 || mem_addr !== exp_addr[a]) begin
                n_bad++;
                $display("FAIL contention_grant%0d: mov=%b addr=%h, need mov=1 addr=%h",
                         a, got_mov, mem_addr, exp_addr[a]);
            end
            step();
            mem_moc = 1'b1;
            step();
            n_cmp++;
            if (ack_d !== (exp_addr[a] == 32'h300) || ack_f !== (exp_addr[a] == 32'h200)) begin
                n_bad++;
                $display("FAIL contention_ack%0d: ack_d=%b ack_f=%b for winner addr %h",
                         a, ack_d, ack_f, exp_addr[a]);
            end
            mem_moc = 1'b0;
        end
        req_f = 1'b0; req_d = 1'b0;
        step(); step();
    endtask

    task automatic test_timeout();
        int ack_at;
        logic err_at_ack;
        req_d = 1'b1; rw_d = 1'b1; addr_d = 32'h500; type_d = 2'b10;
        mem_moc = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        step();
        n_cmp++;
        if (mem_mov !== 1'b1 || mem_addr !== 32'h500) begin
            n_bad++;
            $display("FAIL timeout_issue: mov=%b addr=%h, need 1 00000500", mem_mov, mem_addr);
        end
        ack_at = -1; err_at_ack = 1'b0;
        for (int k = 1; k <= 40 && ack_at < 0; k++) begin
            step();
            if (ack_d) begin
                ack_at = k;
                err_at_ack = err;
            end
        end
        n_cmp++;
        if (ack_at != 16 || err_at_ack !== 1'b1 || mem_mov !== 1'b0 || rdata !== 32'h0000_0C0C) begin
            n_bad++;
            $display("FAIL timeout_ack: ack after %0d cycles err=%b mov=%b rdata=%h, need 16 1 0 00000c0c",
                     ack_at, err_at_ack, mem_mov, rdata);
        end
        req_d = 1'b0;
        step();
        n_cmp++;
        if (ack_d !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse_width: ack_d=%b err=%b, need 0 0", ack_d, err);
        end
        step();
    endtask

    task automatic test_slow_release();
        logic mov_early;
        req_f = 1'b1; addr_f = 32'h80; mem_rdata = 32'h0000_0011;
        step();
        step();
        mem_moc = 1'b1;
        step();
        n_cmp++;
        if (ack_f !== 1'b1 || rdata !== 32'h0000_0011) begin
            n_bad++;
            $display("FAIL slow_ack: ack_f=%b rdata=%h, need 1 00000011", ack_f, rdata);
        end
        // A new fetch is pending while MOC stays high for 5 more cycles.
        addr_f = 32'h84;
        mov_early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_mov) mov_early = 1'b1;
        end
        n_cmp++;
        if (mov_early !== 1'b0) begin
            n_bad++;
            $display("FAIL slow_hold: mem_mov rose while mem_moc high=%b, need 0", mov_early);
        end
        mem_moc = 1'b0;
        step();
        step();
        n_cmp++;
        if (mem_mov !== 1'b1 || mem_addr !== 32'h84) begin
            n_bad++;
            $display("FAIL slow_next: mov=%b addr=%h, need 1 00000084", mem_mov, mem_addr);
        end
        step();
        mem_moc = 1'b1;
        step();
        n_cmp++;
        if (ack_f !== 1'b1) begin
            n_bad++;
            $display("FAIL slow_next_ack: ack_f=%b, need 1", ack_f);
        end
        req_f = 1'b0; mem_moc = 1'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_timeout();
        test_slow_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
